sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

- First-in first-out queue controller that sits directly upstream of the single-port `sram` (32 x 8) and owns its `cs/we/rd/addr/wr_data` pins.
- Turns push/pop requests into SRAM write/read commands using circular read/write pointers and an occupancy counter.
- Returns popped words with a fixed one-cycle latency.
- The SRAM is single-ported, so at most one access is issued per cycle; pop has priority.

## Interface
- `ADDRESS_BITS`, 5, SRAM address width
- `DATA_WIDTH`, 8, word width
- `NUM_REG`, 32, SRAM depth / FIFO capacity (2..2^ADDRESS_BITS, not necessarily a power of two)
- `clk  in  1`  clock, rising edge
- `reset_n  in  1`  reset, asynchronous, active-low
- `push  in  1`  write request
- `push_data  in  DATA_WIDTH`  word to enqueue
- `push_ack  out  1`  push accepted this cycle (combinational)
- `pop  in  1`  read request
- `pop_ack  out  1`  pop accepted this cycle (combinational)
- `pop_valid  out  1`  `pop_data` valid (one cycle after `pop_ack`)
- `pop_data  out  DATA_WIDTH`  dequeued word (= `sram_rd_data`)
- `full  out  1`  count == NUM_REG
- `empty  out  1`  count == 0
- `count  out  ADDRESS_BITS+1`  occupancy
- `sram_cs  out  1`  SRAM chip select, active-high
- `sram_we  out  1`  1 = write
- `sram_rd  out  1`  0 = read (active-low)
- `sram_addr  out  ADDRESS_BITS`  SRAM address
- `sram_wr_data  out  DATA_WIDTH`  SRAM write data
- `sram_rd_data  in  DATA_WIDTH`  SRAM read data; updated at the rising edge that samples a read command

## Operation
**Acceptance**
- `pop_ack = pop & !empty`
- `push_ack = push & !full & !pop_ack`
- A simultaneous push and pop with the FIFO non-empty: pop is served and push stalls.
- With the FIFO empty, pop is ignored and push proceeds.

**SRAM command driving** (combinational from the ack signals)
- Write (`push_ack`): `sram_cs=1`, `sram_we=1`, `sram_rd=1`, `sram_addr=wr_ptr`, `sram_wr_data=push_data`.
- Read (`pop_ack`): `sram_cs=1`, `sram_we=0`, `sram_rd=0`, `sram_addr=rd_ptr`.
- Idle: `sram_cs=0`, `sram_we=0`, `sram_rd=1`, `sram_addr=rd_ptr`, `sram_wr_data=push_data`.

**State updates at the rising edge**
- On `push_ack`: `wr_ptr` advances; `count+1`.
- On `pop_ack`: `rd_ptr` advances; `count-1`.
- Pointers advance as `(ptr == NUM_REG-1) ? 0 : ptr+1`.
- `count` never exceeds NUM_REG and never drops below 0.

**Registered flag**
- `pop_valid` <= `pop_ack`.
- `pop_data` is `sram_rd_data` passed straight through. It is meaningful only while `pop_valid=1`.

## Timing
- **Reset values:** `wr_ptr=0`, `rd_ptr=0`, `count=0`, `pop_valid=0`, `empty=1`, `full=0`. SRAM pins take their idle values.
- **Reset mid-operation:** clears all pointers, the counter and `pop_valid` immediately. SRAM contents are left intact but become unreachable. Any pending `pop_valid` is dropped.
- **Latency:**
  - Push is stored at the edge ending its `push_ack` cycle.
  - Popped data appears with `pop_valid` exactly one cycle after `pop_ack`.
- **Read-after-write:** a word pushed in cycle N can be popped in cycle N+1 (`empty` deasserts after edge N).
- **Throughput:** one access per cycle. Back-to-back pops produce back-to-back `pop_valid`.
- **Flags:** `full`, `empty` and `count` are registered state, decoded combinationally from `count`.
- **Boundaries:**
  - Push when full: `push_ack=0`, no SRAM write.
  - Pop when empty: `pop_ack=0`, `pop_valid` stays 0 the next cycle.

## Configuration
- `SRAM_FIFO_ERR_EN`: adds outputs `overflow` and `underflow`, each 1 bit and sticky.
  - `overflow` sets on `push & full & !pop_ack`.
  - `underflow` sets on `pop & empty`.
  - Both clear only on reset.
- Without the macro, these ports and their logic do not exist. All other behaviour is identical.

## Test plan
1. Reset, then push 0,3,6,…,93 (32 words, +3 each, one per cycle):
   - `push_ack` for all 32.
   - SRAM addresses 0..31 written.
   - `full=1`, `count=32`.
   - A 33rd push gets `push_ack=0`.
2. From full, pop 32 consecutive cycles:
   - `pop_valid` on cycles 2..33.
   - `pop_data` 0,3,…,93 in order.
   - `empty=1` at end.
   - Extra pop gives no `pop_valid`.
3. Wrap-around: push 20, pop 20, push 20, pop 20 with values 100..119:
   - Second batch occupies addresses 20..31 then 0..7.
   - Output order is preserved.
4. `push` and `pop` both held with `count=1`:
   - Pop is served, push stalls for that cycle.
   - Next cycle (now empty) the push is accepted.
   - `count` goes 1→0→1.
5. Assert `reset_n=0` mid-stream with `count=5` and a `pop_ack` in flight:
   - `pop_valid` drops immediately.
   - `count=0`, `empty=1`.
   - After release, push 0x55 then pop returns 0x55.
6. With `SRAM_FIFO_ERR_EN`:
   - Push when full sets `overflow=1`.
   - Pop when empty sets `underflow=1`.
   - Both remain set until reset.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a single-port SRAM; pop has priority over push.
// Define SRAM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sram_fifo_ctrl #(
    parameter int ADDRESS_BITS = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REG      = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    push_ack,
    input  logic                    pop,
    output logic                    pop_ack,
    output logic                    pop_valid,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDRESS_BITS:0]   count,
    output logic                    sram_cs,
    output logic                    sram_we,
    output logic                    sram_rd,
    output logic [ADDRESS_BITS-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [DATA_WIDTH-1:0]   sram_rd_data
`ifdef SRAM_FIFO_ERR_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam logic [ADDRESS_BITS-1:0] LAST_PTR   = (ADDRESS_BITS)'(NUM_REG - 1);
    localparam logic [ADDRESS_BITS:0]   FULL_COUNT = (ADDRESS_BITS + 1)'(NUM_REG);

    logic [ADDRESS_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_BITS:0]   count_q, count_d;
    logic                    pop_valid_q, pop_valid_d;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign pop_ack  = pop & ~empty;
    assign push_ack = push & ~full & ~pop_ack;

    assign pop_valid = pop_valid_q;
    assign pop_data  = sram_rd_data;

    always_comb begin
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        sram_rd      = 1'b1;
        sram_addr    = rd_ptr_q;
        sram_wr_data = push_data;
        if (pop_ack) begin
            sram_cs = 1'b1;
            sram_rd = 1'b0;
        end else if (push_ack) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b1;
            sram_addr = wr_ptr_q;
        end
    end

    // Pointers wrap explicitly so NUM_REG need not be a power of two.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_ack;
        if (push_ack) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (pop_ack) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
        end
    end

`ifdef SRAM_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (push & full & ~pop_ack);
        underflow_d = underflow_q | (pop & empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 32x8 SRAM attached.
// Error-flag checks compile in when SRAM_FIFO_ERR_EN is defined.
module tb_sram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       push_ack;
    logic       pop = 1'b0;
    logic       pop_ack;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       sram_cs;
    logic       sram_we;
    logic       sram_rd;
    logic [4:0] sram_addr;
    logic [7:0] sram_wr_data;
    logic [7:0] sram_rd_data = 8'h00;
`ifdef SRAM_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int compared_cnt = 0;
    int mismatch_cnt = 0;
    logic [7:0] mem [32];

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.ADDRESS_BITS(5), .DATA_WIDTH(8), .NUM_REG(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .push(push), .push_data(push_data), .push_ack(push_ack),
        .pop(pop), .pop_ack(pop_ack), .pop_valid(pop_valid), .pop_data(pop_data),
        .full(full), .empty(empty), .count(count),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_rd(sram_rd),
        .sram_addr(sram_addr), .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
`ifdef SRAM_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // Behavioural single-port SRAM: read data updates at the sampling edge.
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_wr_data;
        if (sram_cs && !sram_rd) sram_rd_data <= mem[sram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared_cnt++;
        if (actual !== expected) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are settled on return.
    task automatic applyStimulus(input logic p, input logic [7:0] d, input logic q);
        @(negedge clk);
        push = p;
        push_data = d;
        pop = q;
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_pop_valid", pop_valid, 0);
        checkOutput("rst_cs", sram_cs, 0);
        checkOutput("rst_rd", sram_rd, 1);
        checkOutput("rst_we", sram_we, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill: 0,3,...,93 to addresses 0..31
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 8'(i * 3), 0);
            checkOutput("fill_push_ack", push_ack, 1);
            checkOutput("fill_addr", sram_addr, i);
            checkOutput("fill_we", sram_we, 1);
            checkOutput("fill_cs", sram_cs, 1);
        end
        applyStimulus(1, 8'd99, 0);
        checkOutput("full_flag", full, 1);
        checkOutput("full_count", count, 32);
        checkOutput("full_push_ack", push_ack, 0);
        checkOutput("full_no_cs", sram_cs, 0);

        // Drain 32 words in order
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 8'h00, 1);
            checkOutput("drain_pop_ack", pop_ack, 1);
            checkOutput("drain_addr", sram_addr, i);
            checkOutput("drain_rd", sram_rd, 0);
            checkOutput("drain_valid", pop_valid, (i > 0) ? 1 : 0);
            if (i > 0) checkOutput("drain_data", pop_data, (i - 1) * 3);
        end
        applyStimulus(0, 8'h00, 1);
        checkOutput("drain_last_valid", pop_valid, 1);
        checkOutput("drain_last_data", pop_data, 93);
        checkOutput("empty_pop_ack", pop_ack, 0);
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_count", count, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("empty_pop_no_valid", pop_valid, 0);

        // Wrap-around: two batches of 20, second spans 20..31,0..7
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 20; i++) begin
                applyStimulus(1, 8'(100 + i), 0);
                checkOutput("wrap_push_ack", push_ack, 1);
                checkOutput("wrap_wr_addr", sram_addr, (pass * 20 + i) % 32);
            end
            for (int i = 0; i < 20; i++) begin
                applyStimulus(0, 8'h00, 1);
                checkOutput("wrap_pop_ack", pop_ack, 1);
                checkOutput("wrap_rd_addr", sram_addr, (pass * 20 + i) % 32);
                if (i > 0) checkOutput("wrap_data", pop_data, 100 + i - 1);
            end
            applyStimulus(0, 8'h00, 0);
            checkOutput("wrap_last_valid", pop_valid, 1);
            checkOutput("wrap_last_data", pop_data, 119);
            checkOutput("wrap_empty", empty, 1);
        end

        // Simultaneous push and pop with count=1
        applyStimulus(1, 8'hA1, 0);
        checkOutput("pp_seed_ack", push_ack, 1);
        applyStimulus(1, 8'hB2, 1);
        checkOutput("pp_count1", count, 1);
        checkOutput("pp_pop_wins", pop_ack, 1);
        checkOutput("pp_push_stall", push_ack, 0);
        applyStimulus(1, 8'hB2, 1);
        checkOutput("pp_count0", count, 0);
        checkOutput("pp_pop_ignored", pop_ack, 0);
        checkOutput("pp_push_now", push_ack, 1);
        checkOutput("pp_valid", pop_valid, 1);
        checkOutput("pp_data", pop_data, 8'hA1);
        applyStimulus(0, 8'h00, 1);
        checkOutput("pp_count1_again", count, 1);
        checkOutput("pp_no_valid", pop_valid, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("pp_data2", pop_data, 8'hB2);
        checkOutput("pp_empty", empty, 1);

        // Reset mid-stream with a pop in flight
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h10 + i), 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("mid_count5", count, 5);
        checkOutput("mid_pop_ack", pop_ack, 1);
        @(posedge clk);
        #1;
        checkOutput("mid_valid_before", pop_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_valid_dropped", pop_valid, 0);
        checkOutput("mid_count0", count, 0);
        checkOutput("mid_empty", empty, 1);
        pop = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 8'h55, 0);
        checkOutput("post_push_addr", sram_addr, 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("post_pop_ack", pop_ack, 1);
        applyStimulus(0, 8'h00, 0);
        checkOutput("post_valid", pop_valid, 1);
        checkOutput("post_data", pop_data, 8'h55);

`ifdef SRAM_FIFO_ERR_EN
        checkOutput("err_clean_ovf", overflow, 0);
        checkOutput("err_clean_unf", underflow, 0);
        applyStimulus(0, 8'h00, 1);
        applyStimulus(0, 8'h00, 0);
        checkOutput("err_underflow", underflow, 1);
        checkOutput("err_no_ovf", overflow, 0);
        for (int i = 0; i < 32; i++) applyStimulus(1, 8'(i), 0);
        applyStimulus(1, 8'hEE, 0);
        applyStimulus(0, 8'h00, 0);
        checkOutput("err_overflow", overflow, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1);
        checkOutput("err_ovf_sticky", overflow, 1);
        checkOutput("err_unf_sticky", underflow, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("err_ovf_reset", overflow, 0);
        checkOutput("err_unf_reset", underflow, 0);
        pop = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
